// File: rtl/sequenciador_servos_pkg.sv
// Shared state/command encodings and default settle time for the servo sequencer.
package sequenciador_servos_pkg;

  localparam int TEMPO_ESPERA_PADRAO = 25000000;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    FECHA   = 4'd1,
    GIRA    = 4'd2,
    ABRE    = 4'd3,
    RETORNA = 4'd4,
    FIM     = 4'd5
  } estado_t;

  typedef enum logic [1:0] {
    CMD_GIRA  = 2'b00,
    CMD_FACE  = 2'b01,
    CMD_FECHA = 2'b10,
    CMD_ABRE  = 2'b11
  } comando_t;

  function automatic logic eh_passo(input estado_t e);
    return (e == FECHA) || (e == GIRA) || (e == ABRE) || (e == RETORNA);
  endfunction

endpackage

// File: rtl/sequenciador_servos_contador_espera.sv
// Loadable settle down-counter: load takes effect next cycle, then counts down to 0 and holds.
// o_fim is high while the count is 0; no backpressure.
module contador_espera #(
  parameter int LARGURA = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_carrega,
  input  logic [LARGURA-1:0] i_valor,
  output logic               o_fim
);

  logic [LARGURA-1:0] r_contagem;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_contagem <= '0;
    end else if (i_carrega) begin
      r_contagem <= i_valor;
    end else if (r_contagem != '0) begin
      r_contagem <= r_contagem - LARGURA'(1);
    end
  end

  assign o_fim = (r_contagem == '0);

endmodule

// File: rtl/sequenciador_servos.sv
// Gripper/rotation servo sequencer; each step holds TEMPO_ESPERA cycles, pronto pulses in FIM.
// Optional SERVO_SEQ_ABORT_EN adds abortar (reroute to ABRE); iniciar while busy is dropped.
module sequenciador_servos
  import sequenciador_servos_pkg::*;
#(
  parameter int TEMPO_ESPERA = TEMPO_ESPERA_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] comando,
`ifdef SERVO_SEQ_ABORT_EN
  input  logic       abortar,
`endif
  output logic       posicao_garra,
  output logic       posicao_giro,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int LARGURA = $clog2(TEMPO_ESPERA + 1);
  // Loaded on entry, so the count reaches 0 on the last of TEMPO_ESPERA cycles.
  localparam logic [LARGURA-1:0] CARGA = LARGURA'(TEMPO_ESPERA - 1);

  estado_t  r_estado, w_prox;
  comando_t r_cmd, w_cmd_prox;
  logic     r_garra, r_giro, r_giro_salvo;
  logic     w_fim, w_carrega;

  contador_espera #(.LARGURA(LARGURA)) u_contador (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_carrega (w_carrega),
    .i_valor   (CARGA),
    .o_fim     (w_fim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_cmd    <= CMD_GIRA;
    end else begin
      r_estado <= w_prox;
      r_cmd    <= w_cmd_prox;
    end
  end

  always_comb begin
    w_prox     = r_estado;
    w_cmd_prox = r_cmd;
    case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
          w_cmd_prox = comando_t'(comando);
          case (comando_t'(comando))
            CMD_GIRA: w_prox = GIRA;
            CMD_ABRE: w_prox = ABRE;
            default:  w_prox = FECHA;
          endcase
        end
      end
      FECHA:   if (w_fim) w_prox = (r_cmd == CMD_FACE) ? GIRA : FIM;
      GIRA:    if (w_fim) w_prox = (r_cmd == CMD_FACE) ? ABRE : FIM;
      ABRE:    if (w_fim) w_prox = (r_cmd == CMD_FACE) ? RETORNA : FIM;
      RETORNA: if (w_fim) w_prox = FIM;
      default: w_prox = OCIOSO;
    endcase
`ifdef SERVO_SEQ_ABORT_EN
    // Rewriting the command to an open makes ABRE finish straight into FIM.
    if (abortar && ((r_estado == FECHA) || (r_estado == GIRA) || (r_estado == RETORNA))) begin
      w_prox     = ABRE;
      w_cmd_prox = CMD_ABRE;
    end
`endif
  end

  assign w_carrega = (w_prox != r_estado) && eh_passo(w_prox);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_garra      <= 1'b0;
      r_giro       <= 1'b0;
      r_giro_salvo <= 1'b0;
    end else begin
      if (r_estado == OCIOSO) begin
        r_giro_salvo <= r_giro;
      end
      if (w_carrega) begin
        case (w_prox)
          FECHA:   r_garra <= 1'b1;
          ABRE:    r_garra <= 1'b0;
          GIRA:    r_giro  <= ~r_giro;
          RETORNA: r_giro  <= r_giro_salvo;
          default: ;
        endcase
      end
    end
  end

  assign posicao_garra = r_garra;
  assign posicao_giro  = r_giro;
  assign ocupado       = (r_estado != OCIOSO);
  assign pronto        = (r_estado == FIM);
  assign db_estado     = r_estado;

endmodule

// File: tb/tb_sequenciador_servos.sv
// Scoreboarded bench for sequenciador_servos with TEMPO_ESPERA=4: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sequenciador_servos;
  import sequenciador_servos_pkg::*;

  localparam int T = 4;

  typedef struct packed {
    logic       garra;
    logic       giro;
    logic       ocupado;
    logic       pronto;
    logic [3:0] estado;
  } saida_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] comando = 2'b00;
`ifdef SERVO_SEQ_ABORT_EN
  logic       abortar = 1'b0;
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  logic       posicao_garra, posicao_giro, ocupado, pronto;
  logic [3:0] db_estado;

  int     checks = 0;
  int     errors = 0;
  saida_t fila[$];
  logic   m_garra = 1'b0;
  logic   m_giro  = 1'b0;

  always #5 clock = ~clock;

  sequenciador_servos #(.TEMPO_ESPERA(T)) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .comando       (comando),
`ifdef SERVO_SEQ_ABORT_EN
    .abortar       (abortar),
`endif
    .posicao_garra (posicao_garra),
    .posicao_giro  (posicao_giro),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  initial begin
    saida_t e;
    saida_t r;
    forever begin
      @(negedge clock);
      if (fila.size() > 0) begin
        e = fila.pop_front();
        r = {posicao_garra, posicao_giro, ocupado, pronto, db_estado};
        checks++;
        if (r !== e) begin
          errors++;
          $display("FAIL saidas t=%0t got garra=%b giro=%b ocupado=%b pronto=%b estado=%0d expected garra=%b giro=%b ocupado=%b pronto=%b estado=%0d",
                   $time, r.garra, r.giro, r.ocupado, r.pronto, r.estado,
                   e.garra, e.giro, e.ocupado, e.pronto, e.estado);
        end
      end
    end
  end

  function automatic saida_t idle();
    return {m_garra, m_giro, 1'b0, 1'b0, OCIOSO};
  endfunction

  task automatic confere(input string nome, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      errors++;
      $display("FAIL %s t=%0t garra=%b giro=%b ocupado=%b pronto=%b estado=%0d",
               nome, $time, posicao_garra, posicao_giro, ocupado, pronto, db_estado);
    end
  endtask

  // One clock cycle: drive this cycle's inputs and record what the outputs must be during it.
  task automatic ciclo(input saida_t e, input logic ini, input logic [1:0] cmd, input logic rst);
    @(posedge clock);
    #1;
    reset   = rst;
    iniciar = ini;
    comando = cmd;
`ifdef SERVO_SEQ_ABORT_EN
    abortar = 1'b0;
`endif
    fila.push_back(e);
  endtask

  // Reference model of one command, cycle 0 = iniciar cycle. Optional disturbances (cycle numbers, -1 = none):
  // re-pulse iniciar, change comando from a cycle on, pulse reset, pulse abortar.
  task automatic executa(input logic [1:0] cmd, input int c_reinicia, input int c_troca,
                         input logic [1:0] v_troca, input int c_reset, input int c_abort);
    estado_t    passos[$];
    estado_t    p;
    logic       giro_antes;
    logic       rst;
    logic       ab;
    logic [1:0] cmd_n;
    int         n;
    giro_antes = m_giro;
    case (cmd)
      2'b00: passos.push_back(GIRA);
      2'b01: begin
        passos.push_back(FECHA);
        passos.push_back(GIRA);
        passos.push_back(ABRE);
        passos.push_back(RETORNA);
      end
      2'b10: passos.push_back(FECHA);
      default: passos.push_back(ABRE);
    endcase
    ciclo(idle(), 1'b1, cmd, 1'b1);
    n = 1;
    while (passos.size() > 0) begin
      p = passos.pop_front();
      case (p)
        FECHA:   m_garra = 1'b1;
        ABRE:    m_garra = 1'b0;
        GIRA:    m_giro  = ~m_giro;
        default: m_giro  = giro_antes;
      endcase
      for (int k = 0; k < T; k++) begin
        rst   = (n != c_reset);
        ab    = ABORT_EN && (n == c_abort) && (p != ABRE);
        cmd_n = (c_troca >= 0 && n >= c_troca) ? v_troca : cmd;
        ciclo({m_garra, m_giro, 1'b1, 1'b0, p}, (n == c_reinicia), cmd_n, rst);
`ifdef SERVO_SEQ_ABORT_EN
        abortar = (n == c_abort);
`endif
        n++;
        if (!rst) begin
          m_garra = 1'b0;
          m_giro  = 1'b0;
          ciclo(idle(), 1'b0, cmd_n, 1'b1);
          return;
        end
        if (ab) begin
          passos.delete();
          passos.push_back(ABRE);
          break;
        end
      end
    end
    cmd_n = (c_troca >= 0 && n >= c_troca) ? v_troca : cmd;
    ciclo({m_garra, m_giro, 1'b1, 1'b1, FIM}, (n == c_reinicia), cmd_n, 1'b1);
  endtask

  initial begin
    int c_reset;
    int c_abort;
    // Reset held low for two cycles.
    ciclo('0, 1'b0, 2'b00, 1'b0);
    ciclo('0, 1'b0, 2'b00, 1'b0);
    @(negedge clock);
    confere("reset", (posicao_garra === 1'b0) && (posicao_giro === 1'b0) && (ocupado === 1'b0)
                     && (pronto === 1'b0) && (db_estado === OCIOSO));
    ciclo(idle(), 1'b0, 2'b00, 1'b1);

    executa(2'b01, -1, -1, 2'b00, -1, -1);
    ciclo(idle(), 1'b0, 2'b00, 1'b1);

    executa(2'b00, -1, -1, 2'b00, -1, -1);
    @(negedge clock);
    confere("espera_gira", (pronto === 1'b1) && (db_estado === FIM) && (posicao_giro === 1'b1));
    executa(2'b00, -1, -1, 2'b00, -1, -1);
    ciclo(idle(), 1'b0, 2'b00, 1'b1);

    executa(2'b01, 6, 2, 2'b11, -1, -1);
    ciclo(idle(), 1'b0, 2'b00, 1'b1);

    executa(2'b01, -1, -1, 2'b00, 7, -1);
    executa(2'b10, -1, -1, 2'b00, -1, -1);
    @(negedge clock);
    confere("espera_fecha", (pronto === 1'b1) && (db_estado === FIM) && (posicao_garra === 1'b1)
                            && (ocupado === 1'b1));

    executa(2'b10, -1, -1, 2'b00, -1, -1);
    executa(2'b11, -1, -1, 2'b00, -1, -1);
    executa(2'b11, -1, -1, 2'b00, -1, -1);
    ciclo(idle(), 1'b0, 2'b00, 1'b1);

    if (ABORT_EN) begin
      executa(2'b00, -1, -1, 2'b00, -1, -1);
      executa(2'b01, -1, -1, 2'b00, -1, 6);
      ciclo(idle(), 1'b0, 2'b00, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      c_reset = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : -1;
      c_abort = (ABORT_EN && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : -1;
      executa(2'($urandom_range(0, 3)), int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
              2'($urandom_range(0, 3)), c_reset, c_abort);
      repeat ($urandom_range(0, 2)) ciclo(idle(), 1'b0, 2'($urandom_range(0, 3)), 1'b1);
    end

    ciclo(idle(), 1'b0, 2'b00, 1'b1);
    ciclo(idle(), 1'b0, 2'b00, 1'b1);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_servos.md
SEQUENCIADOR_SERVOS -- requirements
Module: sequenciador_servos

Interface
REQ-001 Parameter TEMPO_ESPERA, default 25000000, settle cycles per servo step (500 ms at 50 MHz); legal range >= 1.
REQ-002 clock  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 iniciar  input  1  start strobe; sampled only in state OCIOSO.
REQ-005 comando  input  2  move command, sampled with iniciar: 00 toggle rotation, 01 face move, 10 close gripper, 11 open gripper.
REQ-006 posicao_garra  output  1  gripper servo position (0 = open, 1 = closed); drives a controle_servo2_180 posicao input.
REQ-007 posicao_giro  output  1  rotation servo position (0 = 2 deg, 1 = 95 deg); drives a controle_servo2_180 posicao input.
REQ-008 ocupado  output  1  high in every state except OCIOSO.
REQ-009 pronto  output  1  one-cycle pulse on completion of a command.
REQ-010 db_estado  output  4  current state encoding, for debug.

Function
REQ-011 States: OCIOSO, FECHA, GIRA, ABRE, RETORNA, FIM.
REQ-012 In OCIOSO with iniciar=1, the next state follows comando:
- 00 -> GIRA
- 01 -> FECHA
- 10 -> FECHA
- 11 -> ABRE
REQ-013 comando is latched in the iniciar cycle; later changes to comando do not affect the running command.
REQ-014 Position outputs are registered and change on the cycle the step state is entered:
- FECHA: posicao_garra=1.
- ABRE: posicao_garra=0.
- GIRA: posicao_giro inverts.
- RETORNA: posicao_giro restores the value it held before the command.
REQ-015 Each step state lasts exactly TEMPO_ESPERA cycles; the counter reloads on every state entry.
REQ-016 Step order per command:
- 01: FECHA, GIRA, ABRE, RETORNA, FIM.
- 00: GIRA, FIM.
- 10: FECHA, FIM.
- 11: ABRE, FIM.
REQ-017 FIM lasts one cycle with pronto=1, then the block returns to OCIOSO; iniciar is not accepted in FIM.
REQ-018 iniciar asserted while ocupado=1 is ignored and is not queued.
REQ-019 Closing an already-closed gripper, or opening an already-open one, still waits TEMPO_ESPERA cycles.
REQ-020 Settle-counter width is $clog2(TEMPO_ESPERA+1); the counter never wraps.

Reset
REQ-021 reset=0 forces, on the next rising edge of clock:
- state OCIOSO and counter 0;
- posicao_garra=0 and posicao_giro=0;
- ocupado=0 and pronto=0.
REQ-022 Reset mid-command aborts the command immediately; no pronto is issued for it.

Configuration
REQ-023 Macro SERVO_SEQ_ABORT_EN defined: the module adds input abortar (1 bit).
- abortar=1 in FECHA, GIRA or RETORNA -> next state ABRE, full TEMPO_ESPERA wait, then FIM with pronto; RETORNA is skipped.
- abortar=1 in ABRE, OCIOSO or FIM has no effect.
REQ-024 Macro SERVO_SEQ_ABORT_EN undefined: the abortar port and all abort logic are absent.

Structure
REQ-025 Package sequenciador_servos_pkg holds the state enum, the comando encodings and the TEMPO_ESPERA default.
REQ-026 Sub-module contador_espera is a loadable down-counter with a fim flag, instantiated once.

Verification
REQ-027 Run all scenarios with TEMPO_ESPERA=4; cycle 0 is the iniciar cycle.
REQ-028 Reset: hold reset=0 for 2 cycles -> all outputs 0 and db_estado=OCIOSO.
REQ-029 comando=01 from giro=0:
- posicao_garra=1 on cycles 1-8 and 0 from cycle 9;
- posicao_giro=1 on cycles 5-12 and 0 from cycle 13;
- pronto=1 only on cycle 17;
- ocupado=1 on cycles 1-17.
REQ-030 comando=00 twice, back to back: first run -> giro=1 from cycle 1, pronto on cycle 5; second run -> giro returns to 0, one pronto pulse per run.
REQ-031 comando=01 with iniciar pulsed again on cycle 6 and comando changed to 11 on cycle 2 -> timeline identical to the comando=01 scenario (REQ-029), exactly one pronto.
REQ-032 reset=0 on cycle 7 of a comando=01 run -> outputs 0 on cycle 8, no pronto, a new iniciar accepted from cycle 9.
REQ-033 SERVO_SEQ_ABORT_EN defined, comando=01, abortar=1 on cycle 6:
- ABRE on cycles 7-10 with garra=0 and giro=1;
- pronto on cycle 11;
- giro stays 1.
